// File: rtl/vram_oam_responder.sv
// vram_oam_responder: arbitrates background and sprite fetcher reads onto a
// single VRAM port and serves OAM flag-byte reads on an independent OAM port.
// Each request is a level held until its one-cycle response pulse; a per-port
// ack flag stops a held request from being served twice.
// Optional feature macro: VRAM_RANGE_CHECK_EN -- out-of-range requests issue no
// memory strobe and return 0xFF with the normal latency.
module vram_oam_responder #(
    parameter int unsigned VRAM_LATENCY = 2,
    parameter int unsigned OAM_LATENCY  = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        ppu_ena_in,
    input  logic [15:0] bg_addr_in,
    input  logic        bg_addr_valid_in,
    output logic [7:0]  bg_data_out,
    output logic        bg_data_valid_out,
    input  logic [15:0] spr_addr_in,
    input  logic        spr_addr_valid_in,
    output logic [7:0]  spr_data_out,
    output logic        spr_data_valid_out,
    output logic        mem_free_out,
    input  logic [15:0] flag_addr_in,
    input  logic        flag_request_in,
    output logic [7:0]  sprite_flags_out,
    output logic        valid_flags_out,
    output logic [12:0] vram_addr_out,
    output logic        vram_rd_out,
    input  logic [7:0]  vram_data_in,
    output logic [7:0]  oam_addr_out,
    output logic        oam_rd_out,
    input  logic [7:0]  oam_data_in
);

    // Counters are loaded with latency-1 on accept and the data is captured
    // on the edge where they read zero.
    localparam logic [1:0] VRAM_CNT_INIT = 2'(VRAM_LATENCY - 1);
    localparam logic [1:0] OAM_CNT_INIT  = 2'(OAM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_BG  = 2'd1,
        BUSY_SPR = 2'd2
    } vram_state_t;

    vram_state_t state_q, state_d;

    logic        bg_ack_q, spr_ack_q, flag_ack_q;
    logic        bg_elig, spr_elig, flag_elig;
    logic        accept_bg, accept_spr, accept_vram;
    logic        vram_done;
    logic [1:0]  vram_cnt_q;
    logic        vram_oor_q;
    logic [12:0] sel_addr;
    logic        sel_in_range;

    logic        oam_busy_q;
    logic [1:0]  oam_cnt_q;
    logic        oam_oor_q;
    logic        oam_done;
    logic        accept_flag;

    logic        bg_in_range, spr_in_range, flag_in_range;

`ifdef VRAM_RANGE_CHECK_EN
    assign bg_in_range   = (bg_addr_in[15:13] == 3'b100);
    assign spr_in_range  = (spr_addr_in[15:13] == 3'b100);
    assign flag_in_range = (flag_addr_in[15:8] == 8'hFE) && (flag_addr_in[7:0] < 8'hA0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bg_addr_in[15:13], spr_addr_in[15:13], flag_addr_in[15:8]};
    assign bg_in_range      = 1'b1;
    assign spr_in_range     = 1'b1;
    assign flag_in_range    = 1'b1;
`endif

    assign bg_elig   = bg_addr_valid_in  & ~bg_ack_q   & ppu_ena_in;
    assign spr_elig  = spr_addr_valid_in & ~spr_ack_q  & ppu_ena_in;
    assign flag_elig = flag_request_in   & ~flag_ack_q & ppu_ena_in;

    assign mem_free_out = ~((state_q == BUSY_BG) || ((state_q == IDLE) && bg_elig));

    // VRAM arbiter state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // VRAM next state: completion and a new acceptance may share one edge.
    always_comb begin
        state_d    = state_q;
        accept_bg  = 1'b0;
        accept_spr = 1'b0;
        vram_done  = 1'b0;
        case (state_q)
            IDLE: ;
            BUSY_BG, BUSY_SPR: begin
                if (vram_cnt_q == '0) begin
                    vram_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_q == IDLE) || vram_done) begin
            if (spr_elig) begin
                accept_spr = 1'b1;
                state_d    = BUSY_SPR;
            end else if (bg_elig) begin
                accept_bg = 1'b1;
                state_d   = BUSY_BG;
            end
        end
    end

    assign accept_vram  = accept_bg | accept_spr;
    assign sel_addr     = accept_spr ? spr_addr_in[12:0] : bg_addr_in[12:0];
    assign sel_in_range = accept_spr ? spr_in_range : bg_in_range;

    // Ack flags: set on acceptance, cleared whenever the request level is low.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bg_ack_q   <= 1'b0;
            spr_ack_q  <= 1'b0;
            flag_ack_q <= 1'b0;
        end else begin
            bg_ack_q   <= bg_addr_valid_in  ? (bg_ack_q   | accept_bg)   : 1'b0;
            spr_ack_q  <= spr_addr_valid_in ? (spr_ack_q  | accept_spr)  : 1'b0;
            flag_ack_q <= flag_request_in   ? (flag_ack_q | accept_flag) : 1'b0;
        end
    end

    // VRAM datapath: strobe, address, latency count and response capture.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vram_rd_out        <= 1'b0;
            vram_addr_out      <= '0;
            vram_cnt_q         <= '0;
            vram_oor_q         <= 1'b0;
            bg_data_out        <= '0;
            bg_data_valid_out  <= 1'b0;
            spr_data_out       <= '0;
            spr_data_valid_out <= 1'b0;
        end else begin
            vram_rd_out <= accept_vram & sel_in_range;
            if (accept_vram) begin
                vram_addr_out <= sel_addr;
                vram_cnt_q    <= VRAM_CNT_INIT;
                vram_oor_q    <= ~sel_in_range;
            end else if ((state_q != IDLE) && (vram_cnt_q != '0)) begin
                vram_cnt_q <= vram_cnt_q - 2'd1;
            end
            bg_data_valid_out  <= vram_done && (state_q == BUSY_BG);
            spr_data_valid_out <= vram_done && (state_q == BUSY_SPR);
            if (vram_done && (state_q == BUSY_BG))
                bg_data_out <= vram_oor_q ? 8'hFF : vram_data_in;
            if (vram_done && (state_q == BUSY_SPR))
                spr_data_out <= vram_oor_q ? 8'hFF : vram_data_in;
        end
    end

    assign oam_done    = oam_busy_q && (oam_cnt_q == '0);
    assign accept_flag = (~oam_busy_q | oam_done) & flag_elig;

    // OAM path: independent single-outstanding read engine.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            oam_busy_q       <= 1'b0;
            oam_cnt_q        <= '0;
            oam_oor_q        <= 1'b0;
            oam_rd_out       <= 1'b0;
            oam_addr_out     <= '0;
            sprite_flags_out <= '0;
            valid_flags_out  <= 1'b0;
        end else begin
            oam_rd_out <= accept_flag & flag_in_range;
            if (accept_flag) begin
                oam_busy_q   <= 1'b1;
                oam_addr_out <= flag_addr_in[7:0];
                oam_cnt_q    <= OAM_CNT_INIT;
                oam_oor_q    <= ~flag_in_range;
            end else if (oam_done) begin
                oam_busy_q <= 1'b0;
            end else if (oam_busy_q) begin
                oam_cnt_q <= oam_cnt_q - 2'd1;
            end
            valid_flags_out <= oam_done;
            if (oam_done)
                sprite_flags_out <= oam_oor_q ? 8'hFF : oam_data_in;
        end
    end

endmodule

// File: doc/vram_oam_responder.md
VRAM_OAM_RESPONDER -- requirements
Module: vram_oam_responder

Interface
REQ-001 SHALL have parameter VRAM_LATENCY, default 2, meaning edges from vram_rd_out sampled high to vram_data_in valid (range 1..4).
REQ-002 SHALL have parameter OAM_LATENCY, default 2, meaning the same for oam_rd_out/oam_data_in (range 1..4).
REQ-003 SHALL have ports (clock and reset first):
- clk_in  in  1  sole clock, all state on posedge
- rst_n_in  in  1  asynchronous active-low reset
- ppu_ena_in  in  1  high permits accepting new requests
- bg_addr_in  in  16  background fetcher address, held until response
- bg_addr_valid_in  in  1  background request level
- bg_data_out  out  8  background read data
- bg_data_valid_out  out  1  one-cycle background response pulse
- spr_addr_in  in  16  sprite fetcher address, held until response
- spr_addr_valid_in  in  1  sprite request level
- spr_data_out  out  8  sprite read data
- spr_data_valid_out  out  1  one-cycle sprite response pulse
- mem_free_out  out  1  high when background owns no request
- flag_addr_in  in  16  OAM flag byte address
- flag_request_in  in  1  OAM flag request level
- sprite_flags_out  out  8  OAM flag data
- valid_flags_out  out  1  one-cycle flag response pulse
- vram_addr_out  out  13  VRAM byte address (bits 12:0 of request)
- vram_rd_out  out  1  VRAM read strobe, one cycle per access
- vram_data_in  in  8  VRAM read data
- oam_addr_out  out  8  OAM byte address (bits 7:0 of request)
- oam_rd_out  out  1  OAM read strobe, one cycle per access
- oam_data_in  in  8  OAM read data

Function
REQ-004 VRAM path FSM states IDLE, BUSY_BG, BUSY_SPR; IDLE at reset.
REQ-005 Per-port ack flag (bg, spr, flag) set on acceptance, cleared on the edge its valid input is sampled low; request eligible only if valid high, ack flag clear, ppu_ena_in high.
REQ-006 In IDLE with eligible request(s): accept on that edge; sprite wins when both eligible in same cycle; loser stays eligible.
REQ-007 On accept edge N: vram_addr_out registered, vram_rd_out high for exactly the cycle after edge N; FSM to BUSY_BG/BUSY_SPR.
REQ-008 Response: vram_data_in captured at edge N+VRAM_LATENCY into the owner's data_out; owner's data_valid_out high for exactly the following cycle; FSM returns to IDLE on the same edge and may accept a new eligible request on it (throughput one access per VRAM_LATENCY cycles).
REQ-009 data_out holds last captured value between responses; non-owner outputs unchanged.
REQ-010 mem_free_out = 0 when FSM is BUSY_BG, or IDLE with bg request eligible; else 1 (combinational from registered state and inputs).
REQ-011 Valid input dropping while its access is in flight: access completes, response pulse still issued, data discarded by requester.
REQ-012 ppu_ena_in low: no new acceptance on any path; in-flight accesses complete normally.
REQ-013 OAM path independent of VRAM FSM: flag request accepted at edge M when eligible and OAM path idle; oam_rd_out high the cycle after M; oam_data_in captured at M+OAM_LATENCY into sprite_flags_out; valid_flags_out pulses one cycle; path idle again on that edge.
REQ-014 VRAM and OAM accesses may overlap and complete on the same edge; both pulses SHALL appear.

Reset
REQ-015 While rst_n_in low: FSM IDLE, OAM path idle, ack flags clear, all data outputs 0x00, all valid/strobe outputs 0, vram_addr_out 0, oam_addr_out 0; mem_free_out 1 unless bg request present.
REQ-016 Reset asserted mid-access SHALL discard the access; no response pulse after release for it; a request still held valid after release is re-eligible and re-served.

Configuration
REQ-017 Macro VRAM_RANGE_CHECK_EN defined: VRAM request with address outside 0x8000-0x9FFF SHALL issue no vram_rd_out, return 0xFF with the same VRAM_LATENCY timing; flag request outside 0xFE00-0xFE9F SHALL return 0xFF with OAM_LATENCY timing, no oam_rd_out.
REQ-018 Macro undefined: no range check; low address bits used unconditionally.

Verification
REQ-019 bg 0x8010 valid, accepted edge 10, vram_data_in 0x3C at edge 12 -> vram_rd_out one cycle after edge 10, bg_data_out 0x3C with bg_data_valid_out single pulse after edge 12, mem_free_out 0 edges 10-12.
REQ-020 bg and spr requests rise in same cycle -> spr served first; bg accepted on spr response edge; two rd strobes VRAM_LATENCY apart.
REQ-021 spr valid held 6 cycles after response -> exactly one vram_rd_out, one pulse; drop then reassert -> second access.
REQ-022 flag request 0xFE05 concurrent with bg request -> both served; oam_addr_out 0x05; simultaneous pulses when latencies equal.
REQ-023 rst_n_in low one cycle after accept -> no response pulse; outputs zero; held request re-served after release.
REQ-024 With VRAM_RANGE_CHECK_EN, bg 0x7FFF -> no vram_rd_out, bg_data_out 0xFF after VRAM_LATENCY; without it, vram_addr_out 0x1FFF read issued.
